// File: rtl/soi_arb_pkg.sv
// rtl/soi_arb_pkg.sv - shared types and default widths for the SOI access arbiter
package soi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_DATA_W  = 1;

endpackage

// File: rtl/soi_access_arbiter_if.sv
// rtl/soi_access_arbiter_if.sv - requester request/response bundle for the SOI arbiter
interface soi_access_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 1
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_rdata;

  modport master (
    output req_valid, req_write, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // Walk from the farthest slot back to ptr so the closest request wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soi_access_arbiter.sv
// rtl/soi_access_arbiter.sv - shared SOI register with round-robin read/write sequencer
module soi_access_arbiter
  import soi_arb_pkg::*;
#(
  parameter int                NUM_REQ   = DEF_NUM_REQ,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 toggle_en,
  soi_access_arbiter_if.slave  bus,
  output logic [DATA_W-1:0]    soi_value,
  output logic                 busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  op_e                  op_q, op_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    soi_q, soi_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = '0;
    soi_d        = toggle_en ? ~soi_q : soi_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          idx_d   = win_idx;
          op_d    = op_e'(bus.req_write[win_idx]);
          wdata_d = bus.req_wdata[int'(win_idx)*DATA_W +: DATA_W];
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Response carries the value seen before this access's own write.
        rdata_d             = soi_q;
        if (op_q == OP_WRITE) begin
          soi_d = wdata_q;
        end
        resp_valid_d[idx_q] = 1'b1;
        state_d             = ST_RESP;
      end
      ST_RESP: begin
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      op_q         <= OP_READ;
      wdata_q      <= '0;
      soi_q        <= RESET_VAL;
      rdata_q      <= '0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      soi_q        <= soi_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE) ? grant : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign soi_value      = soi_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_soi_access_arbiter.sv
// tb/tb_soi_access_arbiter.sv - scoreboard bench for soi_access_arbiter
module tb_soi_access_arbiter;

  localparam int            N  = 3;
  localparam int            W  = 8;
  localparam logic [W-1:0]  RV = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          toggle_en = 1'b0;
  logic [W-1:0]  soi_value;
  logic          busy;

  soi_access_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus_if ();

  soi_access_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (W),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .toggle_en (toggle_en),
    .bus       (bus_if),
    .soi_value (soi_value),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] rdata;
  } resp_t;

  resp_t        exp_q[$];
  resp_t        got;
  int           cyc      = 0;
  int           free_at  = 0;
  int           acc_at   = -1;
  int           acc_idx  = 0;
  bit           acc_wr   = 1'b0;
  logic [W-1:0] acc_wd   = '0;
  int           m_ptr    = 0;
  int           m_w      = 0;
  logic [W-1:0] m_soi    = RV;
  logic [W-1:0] m_rdata  = '0;
  bit           model_ok = 1'b0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Reference: one access per 3 cycles, read/write lands one cycle after acceptance.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_soi    = RV;
      m_ptr    = 0;
      m_rdata  = '0;
      acc_at   = -1;
      exp_q.delete();
      free_at  = cyc + 1;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (acc_at == cyc) begin
        exp_q.push_back('{acc_idx, m_soi});
        m_rdata = m_soi;
        if (acc_wr) m_soi = acc_wd;
        else if (toggle_en) m_soi = ~m_soi;
      end else if (toggle_en) begin
        m_soi = ~m_soi;
      end
      m_w = pick(bus_if.req_valid, m_ptr);
      if (cyc >= free_at && m_w >= 0) begin
        acc_at  = cyc + 1;
        acc_idx = m_w;
        acc_wr  = bus_if.req_write[m_w];
        acc_wd  = bus_if.req_wdata[m_w*W +: W];
        free_at = cyc + 3;
        m_ptr   = (m_w + 1) % N;
      end
    end
    cyc++;
  end

  logic [N-1:0] exp_rdy;
  int           exp_w;

  always @(negedge clk) begin
    if (model_ok) begin
      total++;
      if (soi_value !== m_soi) begin
        bad++;
        $display("FAIL soi cyc=%0d got=%h exp=%h", cyc, soi_value, m_soi);
      end
      total++;
      if (busy !== (cyc < free_at)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc < free_at));
      end
      exp_rdy = '0;
      exp_w   = pick(bus_if.req_valid, m_ptr);
      if (cyc >= free_at && exp_w >= 0) exp_rdy[exp_w] = 1'b1;
      total++;
      if (bus_if.req_ready !== exp_rdy) begin
        bad++;
        $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, bus_if.req_ready, exp_rdy);
      end
      total++;
      if (bus_if.resp_rdata !== m_rdata) begin
        bad++;
        $display("FAIL rdata_hold cyc=%0d got=%h exp=%h", cyc, bus_if.resp_rdata, m_rdata);
      end
    end
  end

  logic [N-1:0] exp_oh;

  always @(negedge clk) begin
    if (model_ok) begin
      if (bus_if.resp_valid != '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected cyc=%0d got=%b exp=none", cyc, bus_if.resp_valid);
        end else begin
          got    = exp_q.pop_front();
          exp_oh = '0;
          exp_oh[got.idx] = 1'b1;
          if (bus_if.resp_valid !== exp_oh || bus_if.resp_rdata !== got.rdata) begin
            bad++;
            $display("FAIL resp cyc=%0d got=%b/%h exp=%b/%h", cyc,
                     bus_if.resp_valid, bus_if.resp_rdata, exp_oh, got.rdata);
          end
        end
      end else if (exp_q.size() != 0) begin
        total++;
        bad++;
        $display("FAIL resp_missing cyc=%0d got=%b exp_idx=%0d", cyc,
                 bus_if.resp_valid, exp_q[0].idx);
        exp_q.delete();
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] wr, input logic [N*W-1:0] wd);
    bus_if.req_valid = v;
    bus_if.req_write = wr;
    bus_if.req_wdata = wd;
  endtask

  initial begin
    drive('0, '0, '0);
    rst_n     = 1'b0;
    toggle_en = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(6);

    toggle_en = 1'b0;
    step(1);
    drive(3'b001, 3'b001, 24'h00003C);
    step(1);
    drive('0, '0, '0);
    step(4);

    drive(3'b111, 3'b000, '0);
    step(18);
    drive('0, '0, '0);
    step(3);

    toggle_en = 1'b1;
    drive(3'b010, 3'b010, 24'h000F00);
    step(1);
    drive('0, '0, '0);
    step(5);

    toggle_en = 1'b0;
    drive(3'b001, 3'b001, 24'h000077);
    step(1);
    drive('0, '0, '0);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    drive(3'b111, 3'b000, '0);
    step(4);
    drive('0, '0, '0);
    step(3);

    drive(3'b100, 3'b000, '0);
    step(1);
    drive('0, '0, '0);
    step(2);
    drive(3'b111, 3'b000, '0);
    step(12);
    drive('0, '0, '0);
    step(3);

    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom), N'($urandom), (N*W)'($urandom));
      toggle_en = 1'($urandom_range(0, 1));
      rst_n     = ($urandom_range(0, 49) != 0);
      step(1);
    end
    rst_n = 1'b1;
    drive('0, '0, '0);
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
